// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon round controller: state encoding,
// counter width and the per-configuration round count.
package simon_pkg;

  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } simon_ctrl_state_e;

  // Returns 0 for any (word width, key words) pair that is not a Simon variant.
  function automatic int simon_rounds(int ww, int nkw);
    int t;
    t = 32'sd0;
    case (ww)
      32'sd16: t = (nkw == 32'sd4) ? 32'sd32 : 32'sd0;
      32'sd24: t = (nkw == 32'sd3 || nkw == 32'sd4) ? 32'sd36 : 32'sd0;
      32'sd32: t = (nkw == 32'sd3) ? 32'sd42 : (nkw == 32'sd4) ? 32'sd44 : 32'sd0;
      32'sd48: t = (nkw == 32'sd2) ? 32'sd52 : (nkw == 32'sd3) ? 32'sd54 : 32'sd0;
      32'sd64: t = (nkw == 32'sd2) ? 32'sd68 : (nkw == 32'sd3) ? 32'sd69 :
                   (nkw == 32'sd4) ? 32'sd72 : 32'sd0;
      default: t = 32'sd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/simon_round_ctrl_if.sv
// Command/result interface between the bus side and the Simon round controller,
// carrying the sequence-generator and datapath control outputs.
interface simon_round_ctrl_if;
  import simon_pkg::*;

  logic             start_i;
  logic             mode_i;
  logic             abort_i;
  logic             done_ready_i;
  logic             ready_o;
  logic             seq_mode_o;
  logic             seq_rst_o;
  logic             seq_run_o;
  logic             rnd_en_o;
  logic [CNT_W-1:0] round_o;
  logic             first_o;
  logic             last_o;
  logic             ld_o;
  logic             done_o;

  modport master (
    output start_i, mode_i, abort_i, done_ready_i,
    input  ready_o, seq_mode_o, seq_rst_o, seq_run_o, rnd_en_o,
    input  round_o, first_o, last_o, ld_o, done_o
  );

  modport slave (
    input  start_i, mode_i, abort_i, done_ready_i,
    output ready_o, seq_mode_o, seq_rst_o, seq_run_o, rnd_en_o,
    output round_o, first_o, last_o, ld_o, done_o
  );

endinterface

// File: rtl/simon_round_ctrl_chk.sv
// Protocol checker bound into the round controller: the sequence generator
// must never see reset and advance in the same cycle.
module simon_round_ctrl_chk (
  input logic clk,
  input logic arst_n,
  input logic seq_rst,
  input logic seq_run
);

  a_rst_run_excl: assert property (@(posedge clk) disable iff (!arst_n) !(seq_rst && seq_run))
    else $error("seq_rst and seq_run asserted together");

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon round sequencer: IDLE -> LOAD -> RUN (T rounds) -> DONE, driving the
// z-sequence generator controls and the round counter/flags for the datapath.
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int WW  = 16,
  parameter int NKW = 4
) (
  input logic               clk,
  input logic               arst_n,
  simon_round_ctrl_if.slave bus
);

  localparam int T = simon_rounds(WW, NKW);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(T - 32'sd1);

  if (T == 32'sd0) begin : g_illegal_cfg
    $error("simon_round_ctrl: illegal (WW, NKW) pair");
  end

  simon_ctrl_state_e state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              mode_r;
  logic              ready_r;
  logic              seq_rst_r;
  logic              run_r;
  logic              first_r;
  logic              last_r;
  logic              ld_r;
  logic              done_r;
  logic [CNT_W-1:0]  nxt_cnt_s;

  // Next round index while running; decrypt walks the schedule backwards.
  always_comb begin
    nxt_cnt_s = mode_r ? (cnt_r - 7'd1) : (cnt_r + 7'd1);
  end

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 7'd0;
      mode_r    <= 1'b0;
      ready_r   <= 1'b1;
      seq_rst_r <= 1'b0;
      run_r     <= 1'b0;
      first_r   <= 1'b0;
      last_r    <= 1'b0;
      ld_r      <= 1'b0;
      done_r    <= 1'b0;
    end else if (bus.abort_i) begin
      state_r   <= IDLE;
      cnt_r     <= 7'd0;
      ready_r   <= 1'b1;
      seq_rst_r <= 1'b0;
      run_r     <= 1'b0;
      first_r   <= 1'b0;
      last_r    <= 1'b0;
      ld_r      <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start_i) begin
            state_r   <= LOAD;
            mode_r    <= bus.mode_i;
            ready_r   <= 1'b0;
            ld_r      <= 1'b1;
            seq_rst_r <= 1'b1;
          end else begin
            ready_r <= 1'b1;
          end
        end
        LOAD: begin
          state_r   <= RUN;
          cnt_r     <= mode_r ? T_LAST : 7'd0;
          ld_r      <= 1'b0;
          seq_rst_r <= 1'b0;
          run_r     <= 1'b1;
          first_r   <= 1'b1;
          last_r    <= 1'b0;
        end
        RUN: begin
          first_r <= 1'b0;
          if (last_r) begin
            // Counter keeps its end value for the datapath through DONE.
            state_r <= DONE;
            run_r   <= 1'b0;
            last_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cnt_r  <= nxt_cnt_s;
            last_r <= (nxt_cnt_s == (mode_r ? 7'd0 : T_LAST));
          end
        end
        DONE: begin
          if (bus.done_ready_i) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
          end else begin
            done_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 7'd0;
          ready_r   <= 1'b1;
          seq_rst_r <= 1'b0;
          run_r     <= 1'b0;
          first_r   <= 1'b0;
          last_r    <= 1'b0;
          ld_r      <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o    = ready_r;
  assign bus.seq_mode_o = mode_r;
  assign bus.seq_rst_o  = seq_rst_r;
  assign bus.seq_run_o  = run_r;
  assign bus.rnd_en_o   = run_r;
  assign bus.round_o    = cnt_r;
  assign bus.first_o    = first_r;
  assign bus.last_o     = last_r;
  assign bus.ld_o       = ld_r;
  assign bus.done_o     = done_r;

  simon_round_ctrl_chk u_chk (
    .clk     (clk),
    .arst_n  (arst_n),
    .seq_rst (seq_rst_r),
    .seq_run (run_r)
  );

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl: (32,3) encrypt/stall/abort/reset and
// (64,4) decrypt, followed by a random protocol run.
module tb_simon_round_ctrl;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  simon_round_ctrl_if ia ();
  simon_round_ctrl_if ib ();

  simon_round_ctrl #(.WW(32), .NKW(3)) dut_a (.clk(clk), .arst_n(arst_n), .bus(ia));
  simon_round_ctrl #(.WW(64), .NKW(4)) dut_b (.clk(clk), .arst_n(arst_n), .bus(ib));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_ready"}, 32'(ia.ready_o), 32'd1);
    chk({tag, "_round"}, 32'(ia.round_o), 32'd0);
    chk({tag, "_mode"},  32'(ia.seq_mode_o), 32'd0);
    chk({tag, "_strb"},  32'({ia.seq_rst_o, ia.seq_run_o, ia.rnd_en_o, ia.first_o,
                              ia.last_o, ia.ld_o, ia.done_o}), 32'd0);
  endtask

  initial begin
    int rst_cnt;
    int run_cnt;
    int lat;
    int ops;
    int cyc;
    logic done_seen;
    logic exp_ld;

    {ia.start_i, ia.mode_i, ia.abort_i, ia.done_ready_i} = 4'b0;
    {ib.start_i, ib.mode_i, ib.abort_i, ib.done_ready_i} = 4'b0;

    #1 arst_n = 1'b0;
    #1;
    chk_reset_a("rst_a");
    chk("rst_b_ready", 32'(ib.ready_o), 32'd1);
    chk("rst_b_round", 32'(ib.round_o), 32'd0);
    step();
    step();
    #2 arst_n = 1'b1;
    step();
    chk_reset_a("idle_a");

    // Encrypt (32,3): T = 42, done_ready tied high.
    ia.start_i = 1'b1; ia.mode_i = 1'b0; ia.done_ready_i = 1'b1;
    step();
    ia.start_i = 1'b0;
    chk("enc_load_ld", 32'(ia.ld_o), 32'd1);
    chk("enc_load_seqrst", 32'(ia.seq_rst_o), 32'd1);
    chk("enc_load_ready", 32'(ia.ready_o), 32'd0);
    chk("enc_load_run", 32'(ia.seq_run_o), 32'd0);
    for (int i = 0; i < 42; i++) begin
      step();
      chk("enc_round", 32'(ia.round_o), 32'(i));
      chk("enc_rnd_en", 32'(ia.rnd_en_o), 32'd1);
      chk("enc_first", 32'(ia.first_o), 32'(i == 0));
      chk("enc_last", 32'(ia.last_o), 32'(i == 41));
      chk("enc_seqrst", 32'(ia.seq_rst_o), 32'd0);
    end
    step();
    chk("enc_done", 32'(ia.done_o), 32'd1);
    chk("enc_done_round", 32'(ia.round_o), 32'd41);
    chk("enc_done_run", 32'(ia.seq_run_o), 32'd0);
    step();
    chk("enc_after_done", 32'(ia.done_o), 32'd0);
    chk("enc_after_ready", 32'(ia.ready_o), 32'd1);

    // Decrypt (64,4): T = 72.
    ib.start_i = 1'b1; ib.mode_i = 1'b1; ib.done_ready_i = 1'b1;
    step();
    ib.start_i = 1'b0; ib.mode_i = 1'b0;
    rst_cnt = int'(ib.seq_rst_o);
    run_cnt = int'(ib.seq_run_o);
    chk("dec_load_mode", 32'(ib.seq_mode_o), 32'd1);
    chk("dec_load_ld", 32'(ib.ld_o), 32'd1);
    for (int i = 0; i < 72; i++) begin
      step();
      rst_cnt += int'(ib.seq_rst_o);
      run_cnt += int'(ib.seq_run_o);
      chk("dec_round", 32'(ib.round_o), 32'(71 - i));
      chk("dec_mode", 32'(ib.seq_mode_o), 32'd1);
      chk("dec_first", 32'(ib.first_o), 32'(i == 0));
      chk("dec_last", 32'(ib.last_o), 32'(i == 71));
    end
    step();
    rst_cnt += int'(ib.seq_rst_o);
    run_cnt += int'(ib.seq_run_o);
    chk("dec_done", 32'(ib.done_o), 32'd1);
    chk("dec_done_round", 32'(ib.round_o), 32'd0);
    chk("dec_done_mode", 32'(ib.seq_mode_o), 32'd1);
    chk("dec_run_pulses", 32'(run_cnt), 32'd72);
    chk("dec_rst_pulses", 32'(rst_cnt), 32'd1);
    step();
    chk("dec_ready", 32'(ib.ready_o), 32'd1);

    // Handshake stall on A with an ignored start pulse.
    ia.start_i = 1'b1; ia.mode_i = 1'b0; ia.done_ready_i = 1'b0;
    step();
    ia.start_i = 1'b0;
    repeat (43) step();
    for (int i = 0; i < 10; i++) begin
      chk("stall_done", 32'(ia.done_o), 32'd1);
      chk("stall_round", 32'(ia.round_o), 32'd41);
      chk("stall_ld", 32'(ia.ld_o), 32'd0);
      ia.start_i = (i == 4);
      step();
    end
    ia.start_i = 1'b0;
    chk("stall_done_end", 32'(ia.done_o), 32'd1);
    ia.done_ready_i = 1'b1;
    step();
    chk("stall_release_done", 32'(ia.done_o), 32'd0);
    chk("stall_release_ready", 32'(ia.ready_o), 32'd1);
    chk("stall_release_ld", 32'(ia.ld_o), 32'd0);
    step();
    chk("stall_not_queued", 32'(ia.ld_o), 32'd0);

    // Start coinciding with the DONE handshake must not be taken.
    ia.start_i = 1'b1; ia.done_ready_i = 1'b0;
    step();
    ia.start_i = 1'b0;
    repeat (43) step();
    chk("coin_done", 32'(ia.done_o), 32'd1);
    ia.start_i = 1'b1; ia.done_ready_i = 1'b1;
    step();
    chk("coin_ready", 32'(ia.ready_o), 32'd1);
    chk("coin_no_ld", 32'(ia.ld_o), 32'd0);
    step();
    chk("coin_restart_ld", 32'(ia.ld_o), 32'd1);
    ia.start_i = 1'b0; ia.abort_i = 1'b1;
    step();
    ia.abort_i = 1'b0;
    chk("abort_load_ready", 32'(ia.ready_o), 32'd1);

    // Abort at RUN round 5.
    ia.start_i = 1'b1; ia.done_ready_i = 1'b1;
    step();
    ia.start_i = 1'b0;
    repeat (6) step();
    chk("abort_pre_round", 32'(ia.round_o), 32'd5);
    ia.abort_i = 1'b1;
    step();
    ia.abort_i = 1'b0;
    chk("abort_ready", 32'(ia.ready_o), 32'd1);
    chk("abort_round", 32'(ia.round_o), 32'd0);
    chk("abort_run", 32'(ia.seq_run_o), 32'd0);
    done_seen = ia.done_o;
    repeat (5) begin
      step();
      done_seen |= ia.done_o;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    ia.start_i = 1'b1;
    step();
    ia.start_i = 1'b0;
    lat = 1;
    while (!ia.done_o && lat < 100) begin
      step();
      lat++;
    end
    chk("abort_restart_latency", 32'(lat), 32'd44);
    chk("abort_restart_round", 32'(ia.round_o), 32'd41);
    step();

    // Asynchronous reset in the middle of a decrypt run at round 20.
    ia.start_i = 1'b1; ia.mode_i = 1'b1;
    step();
    ia.start_i = 1'b0; ia.mode_i = 1'b0;
    repeat (22) step();
    chk("rrst_pre_round", 32'(ia.round_o), 32'd20);
    chk("rrst_pre_mode", 32'(ia.seq_mode_o), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk_reset_a("rrst");
    #1 arst_n = 1'b1;
    step();
    chk("rrst_idle", 32'(ia.ready_o), 32'd1);

    // Random protocol run of 200 accepted operations.
    ops = 0;
    cyc = 0;
    while (ops < 200 && cyc < 30000) begin
      ia.start_i      = ($urandom_range(0, 3) == 0);
      ia.mode_i       = 1'($urandom_range(0, 1));
      ia.abort_i      = ($urandom_range(0, 63) == 0);
      ia.done_ready_i = 1'($urandom_range(0, 1));
      exp_ld = ia.ready_o && ia.start_i && !ia.abort_i;
      if (exp_ld) ops++;
      step();
      cyc++;
      chk("rand_accept", 32'(ia.ld_o), 32'(exp_ld));
      chk("rand_rst_run_excl", 32'(ia.seq_rst_o & ia.seq_run_o), 32'd0);
    end
    chk("rand_ops_budget", 32'(ops), 32'd200);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
